imem_loader: RTL
================

# imem_loader

Boot-time instruction-memory writer for the 5-stage RISC-V core. It accepts a byte stream over a valid/ready interface, assembles little-endian 32-bit words and writes them sequentially into the instruction memory's write port. It holds the core in reset until the whole image has been written and its checksum verified. The CPU is the reader of instruction memory; this block is its writer and sits between the host link and the `simple_memory` write port.

## Interface
Parameters:
- `ADDR_WIDTH`, 12 — byte-address width of the instruction memory. Capacity is 2^ADDR_WIDTH/4 words.
- `BASE_ADDR`, 0 — byte address of the first word written. Must be word-aligned and below 2^ADDR_WIDTH.

Ports:
- `clock`  in  1  — single clock. All logic is on the rising edge.
- `reset`  in  1  — synchronous, active-high.
- `in_valid`  in  1  — input byte valid.
- `in_data`  in  8  — input byte.
- `in_ready`  out  1  — loader can accept a byte.
- `mem_enable`  out  1  — memory access strobe.
- `mem_write_enable`  out  1  — write strobe.
- `mem_byte_enable`  out  4  — byte lanes. Always 4'b1111 during a write.
- `mem_address`  out  ADDR_WIDTH  — byte address of the current write.
- `mem_write_data`  out  32  — assembled word.
- `cpu_reset`  out  1  — reset to the core. High until the load completes successfully.
- `done`  out  1  — image loaded and checksum correct.
- `error`  out  1  — load failed.

## Operation
- **Handshake:** a byte transfers on a cycle with `in_valid && in_ready`. `in_data` is ignored otherwise. `in_valid` may drop at any time; there is no timeout.
- **Stream format:**
  - 2-byte word count N, low byte first.
  - 4·N data bytes; each word arrives LSB first.
  - 1 checksum byte equal to the XOR of every preceding byte, header included.
- **Running state:** an 8-bit XOR accumulator cleared on reset; every accepted byte except the checksum byte is XORed into it. A 2-bit byte index and a word counter (ADDR_WIDTH-1 bits wide, so N up to capacity is representable).
- **FSM:** HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERROR. Reset → HDR0.
  - HDR0: accept the low count byte → HDR1.
  - HDR1: accept the high count byte, then:
    - if N > (2^ADDR_WIDTH − BASE_ADDR)/4 → ERROR;
    - else if N == 0 → CSUM;
    - else → DATA.
  - DATA: accept a byte into lane `byte_idx` of the word register. On the 4th byte (`byte_idx` == 3) → WRITE.
  - WRITE (exactly 1 cycle):
    - `mem_enable` = `mem_write_enable` = 1, `mem_byte_enable` = 4'b1111.
    - `mem_address` = BASE_ADDR + 4·word_idx, truncated to ADDR_WIDTH.
    - `mem_write_data` = {b3,b2,b1,b0}.
    - word_idx increments. If the new word_idx == N → CSUM, else → DATA.
  - CSUM: accept one byte. If it equals the accumulator → DONE, else → ERROR.
  - DONE and ERROR are terminal; only `reset` leaves them.
- **`in_ready`** is 1 in HDR0, HDR1, DATA and CSUM; 0 in WRITE, DONE and ERROR.
- **Status outputs:**
  - `cpu_reset` = 1 in every state except DONE.
  - `done` = 1 only in DONE.
  - `error` = 1 only in ERROR.
- **Memory outputs outside WRITE:** `mem_enable`, `mem_write_enable` = 0; `mem_byte_enable`, `mem_address`, `mem_write_data` = 0.
- **Reset mid-load:** returns to HDR0 and clears the accumulator and both counters. Words already written stay in memory; the next stream restarts at BASE_ADDR.

## Timing
- **Reset values:** `in_ready`=1, `cpu_reset`=1, `done`=0, `error`=0, every `mem_*` output = 0, state HDR0.
- **Outputs are decoded from registered state only.** There is no combinational path from `in_valid`/`in_data` to any output.
- **Write latency:** 4th byte of a word accepted in cycle k → write strobe in cycle k+1 with `in_ready`=0 → `in_ready`=1 again in k+2.
- **Peak throughput:** 4 bytes per 5 cycles.
- **Completion:** checksum byte accepted in cycle k → `done`=1 and `cpu_reset`=0 from cycle k+1, or `error`=1 from k+1.
- **Oversize count:** HDR1 byte accepted in cycle k → `error`=1 in k+1, with no memory write.

## Test plan
- **Normal 2-word image:** stream 02 00, 93 00 50 00, 13 81 10 00, 43 with continuous `in_valid` → writes 0x00500093 @0x000 and 0x00108113 @0x004, one strobe each with BE=1111. `done`=1 and `cpu_reset`=0 one cycle after the 43 byte. Run a second time with BASE_ADDR=0x100: same data lands at 0x100 and 0x104.
- **Zero-length image:** stream 00 00 00 → no write strobe, `done`=1 after the 3rd byte.
- **Bad checksum:** the 2-word stream above with checksum 44 → both writes occur, `error`=1, `cpu_reset` stays 1, `in_ready`=0 permanently.
- **Oversize count (ADDR_WIDTH=12, BASE_ADDR=0):**
  - 01 04 (N=1025) → `error`=1 the cycle after the 2nd byte, zero writes, further bytes are not accepted.
  - 00 04 (N=1024) is accepted and the last word is written at 0xFFC.
- **Backpressure:** randomized `in_valid` gaps, including `in_valid` held high through WRITE cycles → identical memory contents to the normal case. No byte is taken while `in_ready`=0; exactly 4·N+3 handshakes occur.
- **Reset mid-load:** assert `reset` for 1 cycle after the 6th data byte, then send the full 2-word stream → outputs return to reset values. Writes restart at 0x000, the final contents are correct, and `done`=1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: turns a host byte stream into sequential 32-bit word writes.
// Holds the core in reset until the image has been written and its XOR checksum matches.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_enable,
    output logic                  mem_write_enable,
    output logic [3:0]            mem_byte_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned MaxWords = ((1 << ADDR_WIDTH) - BASE_ADDR) / 4;
    localparam int unsigned IdxW     = ADDR_WIDTH - 1;

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StData,
        StWrite,
        StCsum,
        StDone,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        acc_q, acc_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [IdxW-1:0]   word_idx_q, word_idx_d;
    logic [15:0]       count_q, count_d;
    logic [31:0]       word_q, word_d;
    logic [15:0]       hdr_count;
    logic              accept;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StHdr0;
            acc_q      <= '0;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            count_q    <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
            word_q     <= word_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
        word_d     = word_q;
        hdr_count  = {in_data, count_q[7:0]};
        accept     = in_valid && in_ready;

        unique case (state_q)
            StHdr0: begin
                if (accept) begin
                    count_d[7:0] = in_data;
                    acc_d        = acc_q ^ in_data;
                    state_d      = StHdr1;
                end
            end
            StHdr1: begin
                if (accept) begin
                    count_d[15:8] = in_data;
                    acc_d         = acc_q ^ in_data;
                    if (32'(hdr_count) > MaxWords) begin
                        state_d = StError;
                    end else if (hdr_count == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                    acc_d      = acc_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                word_idx_d = word_idx_q + 1'b1;
                // The counter is one bit wider than a word index, so N == capacity still compares.
                if (32'(word_idx_d) == 32'(count_q)) begin
                    state_d = StCsum;
                end else begin
                    state_d = StData;
                end
            end
            StCsum: begin
                if (accept) begin
                    state_d = (in_data == acc_q) ? StDone : StError;
                end
            end
            StDone:  state_d = StDone;
            StError: state_d = StError;
            default: state_d = StHdr0;
        endcase
    end

    // All outputs are decoded from registered state only.
    always_comb begin
        in_ready         = 1'b0;
        mem_enable       = 1'b0;
        mem_write_enable = 1'b0;
        mem_byte_enable  = 4'b0000;
        mem_address      = '0;
        mem_write_data   = '0;
        cpu_reset        = 1'b1;
        done             = 1'b0;
        error            = 1'b0;

        unique case (state_q)
            StHdr0, StHdr1, StData, StCsum: in_ready = 1'b1;
            StWrite: begin
                mem_enable       = 1'b1;
                mem_write_enable = 1'b1;
                mem_byte_enable  = 4'b1111;
                mem_address      = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({word_idx_q, 2'b00});
                mem_write_data   = word_q;
            end
            StDone: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            StError: error = 1'b1;
            default: ;
        endcase
    end

endmodule
